fp_divider: RTL and testbench
=============================

# fp_divider

Sequential IEEE-754 single-precision divider, the inverse operation of the FPALU multiplier. It computes `result = a / b` using restoring division at one quotient bit per clock, with a start/done handshake. Exponent/special-case conventions match the FPALU multiplier: no denormals, no NaN generation, truncation instead of rounding. It sits beside the multiplier in the FPALU and is issued by the ALU control for divide ops.

## Interface
- none: no parameters; the format is fixed at 32-bit single precision.

- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request a divide; accepted only in IDLE.
- `a` in 32: dividend, sampled on the accepting edge.
- `b` in 32: divisor, sampled on the accepting edge.
- `busy` out 1: high from the accepting edge until completion.
- `done` out 1: one-cycle pulse; `result` is valid from this cycle on.
- `result` out 32: quotient; held until the next completion.
- `div_by_zero` out 1: registered with `result`; 1 when `b` is zero.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: iterates quotient bits.
  - FINISH: normalizes and packs.
- IDLE with `start=1`:
  - Latch `sign = a[31]^b[31]`, `ea`, `eb`, `ma = {1,a[22:0]}`, `mb = {1,b[22:0]}`.
  - Set `busy=1`.
  - Any special case → FINISH directly with the packed result precomputed; otherwise → CALC with `rem = ma` (25-bit), `cnt = 0`.
- Special-case priority, sign always `sign`:
  1. `eb == 0` → `{sign, FF, 0}`, `div_by_zero = 1`. This includes `a == 0`.
  2. `ea == 0` → `{sign, 00, 0}`.
  3. `ea == FF` → `{sign, FF, 0}`.
  4. `eb == FF` → `{sign, 00, 0}`.
- CALC, per cycle:
  - If `rem >= mb`: `q = {q[23:0],1}` and `rem = (rem - mb) << 1`.
  - Else: `q = {q[23:0],0}` and `rem = rem << 1`.
  - `cnt++`.
  - After 25 bits (`cnt == 24` processed) → FINISH.
  - Result: `q[24:0] = floor(ma/mb · 2^24)`.
- FINISH, normalization:
  - `q[24] = 1`: `mant = q[23:1]`, `e = ea - eb + 127`.
  - Else: `mant = q[22:0]`, `e = ea - eb + 126`.
  - `e` is 10-bit signed.
- FINISH, range check and completion:
  - `e >= 255` → `{sign, FF, 0}` (overflow).
  - `e <= 0` → `{sign, 00, 0}` (underflow).
  - Else → `{sign, e[7:0], mant}`.
  - Register `result` and `div_by_zero`, pulse `done`, drop `busy`, → IDLE.
- `start` while busy is ignored and does not queue. Inputs `a`/`b` may change freely after acceptance.

## Timing
- Reset (`rst_n = 0` at an edge):
  - State → IDLE.
  - `busy = 0`, `done = 0`, `result = 32'h0`, `div_by_zero = 0`.
  - Takes priority over all activity. Reset mid-CALC aborts with no `done`.
- Normal divide: start accepted at edge E0, CALC occupies E1..E25, FINISH registers outputs at E26.
  - `done` is high for the cycle after E26: 26 clocks start→done.
- Special case: outputs registered at E1, so latency is 1 clock, with no CALC cycles.
- `busy` is high in every cycle between E0 and the completion edge. It is low in the `done` cycle.
- Back-to-back operation: `start` may be high in the `done` cycle. It is accepted, since the state is IDLE, giving a new op every 27 clocks.
- `result` and `div_by_zero` change only on a completion edge or on reset.

## Test plan
- 6.0/2.0: `a=40C00000`, `b=40000000` → `result=40400000`, `div_by_zero=0`, `done` exactly 26 clocks after start, `busy` high 26 cycles.
- 1/3 and sign: `3F800000`/`40400000` → `3EAAAAAA` (truncated); `C0F00000`/`40200000` (−7.5/2.5) → `C0400000`.
- Divide by zero: `40A00000`/`00000000` → `7F800000`, `div_by_zero=1`, `done` 1 clock after start. `00000000`/`00000000` → `7F800000`, `div_by_zero=1`.
- Range: `7F000000`/`00800000` → `7F800000` (overflow, `div_by_zero=0`). `00800000`/`7F000000` → `00000000` (underflow). `7F800000`/`40000000` → `7F800000`. `40000000`/`FF800000` → `80000000`.
- Handshake: pulse `start` again at E5 of an active op → ignored, only one `done`, result of the first op. `start` held high in the `done` cycle → second op accepted, second `done` 26 clocks later.
- Reset: assert `rst_n=0` at E10 of a divide → next cycle `busy=0`, `done=0`, `result=0`, `div_by_zero=0`, and no `done` ever appears for the aborted op.

Source files
------------

// File: rtl/fp_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_divider_if
//  Description : Request/response bundle for the sequential single-precision
//                divider. The master issues operands with start; the slave
//                returns busy/done and the registered quotient.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fp_divider_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/fp_divider.sv
`default_nettype none
// ============================================================================
//  Module      : fp_divider
//  Description : IEEE-754 single-precision divider, restoring division at one
//                quotient bit per clock. No denormals, no NaN generation, and
//                the quotient is truncated rather than rounded.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_divider (
    input  wire logic    clk,
    input  wire logic    rst_n,
    fp_divider_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic               r_sign;
    logic [7:0]         r_ea;
    logic [7:0]         r_eb;
    logic [23:0]        r_mb;
    logic [24:0]        r_rem;
    logic [24:0]        r_q;
    logic [4:0]         r_cnt;
    logic               r_special;
    logic [31:0]        r_pre_res;
    logic               r_pre_dbz;
    logic [31:0]        r_result;
    logic               r_dbz;
    logic               r_busy;
    logic               r_done;

    logic               w_sign;
    logic [7:0]         w_a_exp;
    logic [7:0]         w_b_exp;
    logic               w_special;
    logic [31:0]        w_pre_res;
    logic               w_pre_dbz;
    logic               w_rem_ge;
    logic [23:0]        w_diff;
    logic [22:0]        w_mant;
    logic signed [9:0]  w_e;
    logic [31:0]        w_packed;

    assign w_sign  = bus.a[31] ^ bus.b[31];
    assign w_a_exp = bus.a[30:23];
    assign w_b_exp = bus.b[30:23];

    // Special-operand classification on the incoming operands, in priority order
    always_comb begin
        w_special = 1'b1;
        w_pre_dbz = 1'b0;
        w_pre_res = {w_sign, 8'hFF, 23'd0};
        if (w_b_exp == 8'h00) begin
            w_pre_dbz = 1'b1;
        end else if (w_a_exp == 8'h00) begin
            w_pre_res = {w_sign, 8'h00, 23'd0};
        end else if (w_a_exp == 8'hFF) begin
            w_pre_res = {w_sign, 8'hFF, 23'd0};
        end else if (w_b_exp == 8'hFF) begin
            w_pre_res = {w_sign, 8'h00, 23'd0};
        end else begin
            w_special = 1'b0;
        end
    end

    // The true difference is always below mb, so 24 bits hold it exactly
    assign w_rem_ge = (r_rem >= {1'b0, r_mb});
    assign w_diff   = r_rem[23:0] - r_mb;

    // Quotient lies in (0.5, 2) scaled by 2^24; bit 24 selects the normalization
    assign w_mant = r_q[24] ? r_q[23:1] : r_q[22:0];
    assign w_e    = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb})
                  + (r_q[24] ? 10'sd127 : 10'sd126);

    // Exponent range check and final packing
    always_comb begin
        w_packed = {r_sign, w_e[7:0], w_mant};
        if (w_e >= 10'sd255) begin
            w_packed = {r_sign, 8'hFF, 23'd0};
        end else if (w_e <= 10'sd0) begin
            w_packed = {r_sign, 8'h00, 23'd0};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next_state = w_special ? FINISH : CALC;
                end
            end
            CALC: begin
                if (r_cnt == 5'd24) begin
                    w_next_state = FINISH;
                end
            end
            FINISH: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand capture, quotient iteration and result registration
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sign    <= 1'b0;
            r_ea      <= 8'd0;
            r_eb      <= 8'd0;
            r_mb      <= 24'd0;
            r_rem     <= 25'd0;
            r_q       <= 25'd0;
            r_cnt     <= 5'd0;
            r_special <= 1'b0;
            r_pre_res <= 32'd0;
            r_pre_dbz <= 1'b0;
            r_result  <= 32'd0;
            r_dbz     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_sign    <= w_sign;
                        r_ea      <= w_a_exp;
                        r_eb      <= w_b_exp;
                        r_mb      <= {1'b1, bus.b[22:0]};
                        r_rem     <= {2'b01, bus.a[22:0]};
                        r_q       <= 25'd0;
                        r_cnt     <= 5'd0;
                        r_special <= w_special;
                        r_pre_res <= w_pre_res;
                        r_pre_dbz <= w_pre_dbz;
                        r_busy    <= 1'b1;
                    end
                end
                CALC: begin
                    if (w_rem_ge) begin
                        r_q   <= {r_q[23:0], 1'b1};
                        r_rem <= {w_diff, 1'b0};
                    end else begin
                        r_q   <= {r_q[23:0], 1'b0};
                        r_rem <= {r_rem[23:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 5'd1;
                end
                FINISH: begin
                    r_result <= r_special ? r_pre_res : w_packed;
                    r_dbz    <= r_special ? r_pre_dbz : 1'b0;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.result      = r_result;
    assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_fp_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_divider
//  Description : Directed self-checking bench for fp_divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_divider;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    fp_divider_if dif ();

    fp_divider u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op; returns at the sample point of the done cycle (or timeout)
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                          output logic [31:0] res, output logic dbz,
                          output int lat, output int bcnt);
        @(negedge clk);
        dif.start = 1'b1;
        dif.a     = ia;
        dif.b     = ib;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        dif.a     = $urandom;
        dif.b     = $urandom;
        lat  = 0;
        bcnt = 0;
        while (dif.done !== 1'b1 && lat < 100) begin
            if (dif.busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = dif.result;
        dbz = dif.div_by_zero;
    endtask

    task automatic vec(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] exp_res, input logic exp_dbz, input int exp_lat);
        logic [31:0] res;
        logic        dbz;
        int          lat;
        int          bcnt;
        run_op(ia, ib, res, dbz, lat, bcnt);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_cycles"}, bcnt, exp_lat);
        chk({tag, "_result"}, res, exp_res);
        chk({tag, "_dbz"}, {31'd0, dbz}, {31'd0, exp_dbz});
        chk({tag, "_busy_in_done"}, {31'd0, dif.busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {31'd0, dif.done}, 32'd0);
        chk({tag, "_held"}, dif.result, exp_res);
    endtask

    initial begin
        logic [31:0] res;
        logic        dbz;
        int          lat;
        int          bcnt;
        int          dones;
        logic [31:0] first_res;

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        dif.start = 1'b0;
        dif.a     = 32'd0;
        dif.b     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",   {31'd0, dif.busy},        32'd0);
        chk("reset_done",   {31'd0, dif.done},        32'd0);
        chk("reset_result", dif.result,               32'd0);
        chk("reset_dbz",    {31'd0, dif.div_by_zero}, 32'd0);
        rst_n = 1'b1;

        // Normal divides
        vec("six_by_two",   32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 26);
        vec("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 26);
        vec("neg_7p5_2p5",  32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0, 26);

        // Special cases, single-cycle latency
        vec("div_zero",     32'h40A00000, 32'h00000000, 32'h7F800000, 1'b1, 1);
        vec("zero_zero",    32'h00000000, 32'h00000000, 32'h7F800000, 1'b1, 1);
        vec("inf_by_two",   32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 1);
        vec("two_by_ninf",  32'h40000000, 32'hFF800000, 32'h80000000, 1'b0, 1);

        // Range limits through the iterative path
        vec("overflow",     32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 26);
        vec("underflow",    32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 26);

        // start during an active op is ignored
        @(negedge clk);
        dif.start = 1'b1;
        dif.a     = 32'h40C00000;
        dif.b     = 32'h40000000;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        dif.start = 1'b1;
        dif.a     = 32'h3F800000;
        dif.b     = 32'h40400000;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        dones     = 0;
        first_res = 32'hDEADBEEF;
        for (int i = 0; i < 60; i++) begin
            if (dif.done === 1'b1) begin
                if (dones == 0) first_res = dif.result;
                dones++;
            end
            @(posedge clk);
            #1;
        end
        chk("ignored_start_dones",  dones, 1);
        chk("ignored_start_result", first_res, 32'h40400000);

        // Back-to-back: start held in the done cycle
        run_op(32'h3F800000, 32'h40400000, res, dbz, lat, bcnt);
        chk("b2b_first_result", res, 32'h3EAAAAAA);
        dif.start = 1'b1;
        dif.a     = 32'hC0F00000;
        dif.b     = 32'h40200000;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        lat = 0;
        while (dif.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_second_latency", lat, 26);
        chk("b2b_second_result",  dif.result, 32'hC0400000);

        // Reset in the middle of a divide
        @(negedge clk);
        dif.start = 1'b1;
        dif.a     = 32'h40C00000;
        dif.b     = 32'h40000000;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_busy",   {31'd0, dif.busy},        32'd0);
        chk("midreset_done",   {31'd0, dif.done},        32'd0);
        chk("midreset_result", dif.result,               32'd0);
        chk("midreset_dbz",    {31'd0, dif.div_by_zero}, 32'd0);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (dif.done === 1'b1) dones++;
            @(posedge clk);
            #1;
        end
        chk("midreset_no_done", dones, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
